uart_text_console: RTL and testbench

UART_TEXT_CONSOLE -- requirements
Module: uart_text_console

---
 rtl/uart_text_console_pkg.sv | 23 ++
 rtl/console_ram.sv | 24 ++
 rtl/uart_text_console.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_text_console.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_text_console_pkg.sv
// Shared constants and state encoding for the UART text console.
package uart_text_console_pkg;

    // Character codes the console reacts to
    localparam logic [7:0] ChrSpace   = 8'h20;
    localparam logic [7:0] ChrBs      = 8'h08;
    localparam logic [7:0] ChrLf      = 8'h0A;
    localparam logic [7:0] ChrFf      = 8'h0C;
    localparam logic [7:0] ChrCr      = 8'h0D;
    localparam logic [7:0] ChrPrintLo = 8'h20;
    localparam logic [7:0] ChrPrintHi = 8'h7E;

    typedef enum logic [1:0] {
        StClrAll,
        StIdle,
        StClrRow
    } state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ChrPrintLo) && (c <= ChrPrintHi);
    endfunction

endpackage

// File: rtl/console_ram.sv
// Simple dual-port character store: one synchronous write port, one synchronous read port.
// A read of the cell being written in the same cycle returns the old contents.
module console_ram #(
    parameter int unsigned AddrWidth = 6
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [7:0]           wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [7:0]           rdata_o
);

    logic [7:0] mem [2**AddrWidth];

    // Write port and registered read port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/uart_text_console.sv
// Text console fed by a UART byte stream: cursor handling, control characters,
// scroll/wrap at the bottom and background clearing of the character store.
module uart_text_console
    import uart_text_console_pkg::*;
#(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 16,
    parameter int unsigned SCROLL = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [7:0]              i_RX_Data,
    input  logic                    i_RX_DataValid,
    input  logic [$clog2(ROWS)-1:0] i_rdRow,
    input  logic [$clog2(COLS)-1:0] i_rdCol,
    output logic [7:0]              o_character,
    output logic [$clog2(ROWS)-1:0] o_cursorRow,
    output logic [$clog2(COLS)-1:0] o_cursorCol,
    output logic                    o_busy,
    output logic                    o_drop
);

    localparam int unsigned RowW  = $clog2(ROWS);
    localparam int unsigned ColW  = $clog2(COLS);
    localparam int unsigned AddrW = RowW + ColW;

    localparam logic [RowW-1:0]  LastRow  = RowW'(ROWS - 1);
    localparam logic [ColW-1:0]  LastCol  = ColW'(COLS - 1);
    localparam logic [AddrW-1:0] LastCell = AddrW'(ROWS * COLS - 1);

    state_e           state_q, state_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [ColW-1:0]  col_q, col_d;
    logic [RowW-1:0]  top_q, top_d;
    logic [RowW-1:0]  clr_row_q, clr_row_d;
    logic [AddrW-1:0] clr_cnt_q, clr_cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       pend_data_q, pend_data_d;
    logic             drop_q, drop_d;

    logic             ram_we;
    logic [AddrW-1:0] ram_waddr;
    logic [7:0]       ram_wdata;
    logic [AddrW-1:0] ram_raddr;
    logic [7:0]       ram_rdata;

    logic             take;
    logic [7:0]       cur_byte;
    logic             newline;
    logic [RowW-1:0]  cur_phys_row;
    logic [RowW-1:0]  rd_phys_row;
    logic [ColW-1:0]  col_dec;

    assign cur_phys_row = row_q + top_q;
    assign rd_phys_row  = i_rdRow + top_q;
    assign col_dec      = col_q - 1'b1;
    assign ram_raddr    = {rd_phys_row, i_rdCol};

    console_ram #(
        .AddrWidth(AddrW)
    ) u_ram (
        .clk_i  (i_clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(ram_wdata),
        .raddr_i(ram_raddr),
        .rdata_o(ram_rdata)
    );

    // Next-state: clear sequencing, byte intake/pending, cursor and scroll handling
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        top_d        = top_q;
        clr_row_d    = clr_row_q;
        clr_cnt_d    = clr_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        drop_d       = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = clr_cnt_q;
        ram_wdata    = ChrSpace;
        take         = 1'b0;
        cur_byte     = pend_data_q;
        newline      = 1'b0;

        unique case (state_q)
            StClrAll: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LastCell) begin
                    state_d = StIdle;
                end
            end
            StClrRow: begin
                ram_we    = 1'b1;
                ram_waddr = {clr_row_q, clr_cnt_q[ColW-1:0]};
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q[ColW-1:0] == LastCol) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                // The held byte goes first; a byte arriving alongside it takes its slot
                if (pend_valid_q) begin
                    take         = 1'b1;
                    cur_byte     = pend_data_q;
                    pend_valid_d = i_RX_DataValid;
                    if (i_RX_DataValid) begin
                        pend_data_d = i_RX_Data;
                    end
                end else if (i_RX_DataValid) begin
                    take     = 1'b1;
                    cur_byte = i_RX_Data;
                end
            end
            default: state_d = StClrAll;
        endcase

        // While clearing, one byte can wait; anything beyond that is lost
        if (state_q != StIdle && i_RX_DataValid) begin
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_data_d  = i_RX_Data;
            end else begin
                drop_d = 1'b1;
            end
        end

        if (take) begin
            if (is_printable(cur_byte)) begin
                ram_we    = 1'b1;
                ram_waddr = {cur_phys_row, col_q};
                ram_wdata = cur_byte;
                if (col_q == LastCol) begin
                    col_d   = '0;
                    newline = 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                case (cur_byte)
                    ChrCr: col_d = '0;
                    ChrLf: begin
                        col_d   = '0;
                        newline = 1'b1;
                    end
                    ChrBs: begin
                        if (col_q != '0) begin
                            col_d     = col_dec;
                            ram_we    = 1'b1;
                            ram_waddr = {cur_phys_row, col_dec};
                            ram_wdata = ChrSpace;
                        end
                    end
                    ChrFf: begin
                        row_d     = '0;
                        col_d     = '0;
                        top_d     = '0;
                        clr_cnt_d = '0;
                        state_d   = StClrAll;
                    end
                    default: ;
                endcase
            end

            // Scroll and wrap both blank the physical row currently at the top:
            // after a scroll it becomes the bottom, after a wrap it is logical row 0.
            if (newline) begin
                if (row_q != LastRow) begin
                    row_d = row_q + 1'b1;
                end else begin
                    clr_row_d = top_q;
                    clr_cnt_d = '0;
                    state_d   = StClrRow;
                    if (SCROLL != 0) begin
                        top_d = top_q + 1'b1;
                    end else begin
                        row_d = '0;
                    end
                end
            end
        end
    end

    // State register with synchronous reset into a full clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StClrAll;
            row_q        <= '0;
            col_q        <= '0;
            top_q        <= '0;
            clr_row_q    <= '0;
            clr_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            top_q        <= top_d;
            clr_row_q    <= clr_row_d;
            clr_cnt_q    <= clr_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            drop_q       <= drop_d;
        end
    end

    // Store contents are stale during a full clear, so present blanks instead
    assign o_character = (state_q == StClrAll) ? ChrSpace : ram_rdata;
    assign o_cursorRow = row_q;
    assign o_cursorCol = col_q;
    assign o_busy      = (state_q != StIdle);
    assign o_drop      = drop_q;

endmodule

// File: tb/tb_uart_text_console.sv
// Self-checking bench: a wrap-mode and a scroll-mode console share one byte stream and are
// compared every cycle against a logical-screen reference model.
module tb_uart_text_console;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 16;
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;

    logic [7:0]    chr0, chr1;
    logic [RW-1:0] crow0, crow1;
    logic [CW-1:0] ccol0, ccol1;
    logic          busy0, busy1, drop0, drop1;

    int errors = 0;
    int checks = 0;

    // Reference model: index 0 wraps, index 1 scrolls; screen kept in logical order
    logic [7:0] m_scr [2][ROWS][COLS];
    int         m_row [2];
    int         m_col [2];
    int         m_busy[2];
    bit         m_all [2];
    bit         m_pv  [2];
    logic [7:0] m_pb  [2];
    bit         m_drop[2];

    always #5 clk = ~clk;

    uart_text_console #(.ROWS(ROWS), .COLS(COLS), .SCROLL(0)) u_dut_wrap (
        .i_clk(clk), .i_rst(rst), .i_RX_Data(rx_data), .i_RX_DataValid(rx_valid),
        .i_rdRow(rd_row), .i_rdCol(rd_col), .o_character(chr0), .o_cursorRow(crow0),
        .o_cursorCol(ccol0), .o_busy(busy0), .o_drop(drop0)
    );

    uart_text_console #(.ROWS(ROWS), .COLS(COLS), .SCROLL(1)) u_dut_scroll (
        .i_clk(clk), .i_rst(rst), .i_RX_Data(rx_data), .i_RX_DataValid(rx_valid),
        .i_rdRow(rd_row), .i_rdCol(rd_col), .o_character(chr1), .o_cursorRow(crow1),
        .o_cursorCol(ccol1), .o_busy(busy1), .o_drop(drop1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_blank_row(input int s, input int r);
        for (int c = 0; c < COLS; c++) m_scr[s][r][c] = 8'h20;
    endtask

    task automatic m_clear(input int s);
        for (int r = 0; r < ROWS; r++) m_blank_row(s, r);
        m_row[s]  = 0;
        m_col[s]  = 0;
        m_busy[s] = CELLS;
        m_all[s]  = 1'b1;
    endtask

    task automatic m_reset(input int s);
        m_clear(s);
        m_pv[s]   = 1'b0;
        m_drop[s] = 1'b0;
    endtask

    task automatic m_newline(input int s);
        if (m_row[s] < ROWS - 1) begin
            m_row[s]++;
        end else begin
            m_busy[s] = COLS;
            if (s == 1) begin
                for (int r = 0; r < ROWS - 1; r++)
                    for (int c = 0; c < COLS; c++) m_scr[s][r][c] = m_scr[s][r+1][c];
                m_blank_row(s, ROWS - 1);
            end else begin
                m_row[s] = 0;
                m_blank_row(s, 0);
            end
        end
    endtask

    task automatic m_process(input int s, input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_scr[s][m_row[s]][m_col[s]] = b;
            if (m_col[s] == COLS - 1) begin
                m_col[s] = 0;
                m_newline(s);
            end else begin
                m_col[s]++;
            end
        end else if (b == 8'h0D) begin
            m_col[s] = 0;
        end else if (b == 8'h0A) begin
            m_col[s] = 0;
            m_newline(s);
        end else if (b == 8'h08) begin
            if (m_col[s] > 0) begin
                m_col[s]--;
                m_scr[s][m_row[s]][m_col[s]] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            m_clear(s);
        end
    endtask

    task automatic m_step(input int s, input bit v, input logic [7:0] b);
        logic [7:0] held;
        m_drop[s] = 1'b0;
        if (m_busy[s] > 0) begin
            m_busy[s]--;
            if (m_busy[s] == 0) m_all[s] = 1'b0;
            if (v) begin
                if (!m_pv[s]) begin
                    m_pv[s] = 1'b1;
                    m_pb[s] = b;
                end else begin
                    m_drop[s] = 1'b1;
                end
            end
        end else if (m_pv[s]) begin
            held    = m_pb[s];
            m_pv[s] = v;
            m_pb[s] = b;
            m_process(s, held);
        end else if (v) begin
            m_process(s, b);
        end
    endtask

    task automatic tick(input bit v, input logic [7:0] b);
        rx_valid = v;
        rx_data  = b;
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            if (rst) m_reset(s);
            else m_step(s, v, b);
        end
        #1;
        rx_valid = 1'b0;
        check_eq("busy_wrap", 32'(busy0), 32'(m_busy[0] > 0));
        check_eq("busy_scroll", 32'(busy1), 32'(m_busy[1] > 0));
        check_eq("drop_wrap", 32'(drop0), 32'(m_drop[0]));
        check_eq("drop_scroll", 32'(drop1), 32'(m_drop[1]));
        check_eq("row_wrap", 32'(crow0), 32'(m_row[0]));
        check_eq("row_scroll", 32'(crow1), 32'(m_row[1]));
        check_eq("col_wrap", 32'(ccol0), 32'(m_col[0]));
        check_eq("col_scroll", 32'(ccol1), 32'(m_col[1]));
        if (m_all[0]) check_eq("blank_wrap", 32'(chr0), 32'h20);
        if (m_all[1]) check_eq("blank_scroll", 32'(chr1), 32'h20);
    endtask

    task automatic settle();
        for (int i = 0; i < CELLS + 4 * COLS; i++) begin
            if (m_busy[0] == 0 && m_busy[1] == 0 && !m_pv[0] && !m_pv[1]) break;
            tick(1'b0, 8'h00);
        end
    endtask

    task automatic read_cell(input int r, input int c);
        rd_row = RW'(r);
        rd_col = CW'(c);
        tick(1'b0, 8'h00);
    endtask

    task automatic scan_all();
        settle();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c);
                check_eq($sformatf("cell_wrap r%0d c%0d", r, c), 32'(chr0), 32'(m_scr[0][r][c]));
                check_eq($sformatf("cell_scroll r%0d c%0d", r, c), 32'(chr1),
                         32'(m_scr[1][r][c]));
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b);
    endtask

    initial begin
        int cnt0, cnt1, pick;
        logic [7:0] b;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_row   = '0;
        rd_col   = '0;

        // Reset state and power-up clear
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        check_eq("reset_busy", 32'(busy1), 32'h1);
        check_eq("reset_char", 32'(chr1), 32'h20);
        rst = 1'b0;
        scan_all();
        check_eq("init_row", 32'(crow1), 32'h0);
        check_eq("init_col", 32'(ccol1), 32'h0);

        // Backspace handling and underflow at column 0
        send("A");
        send("B");
        send(8'h08);
        check_eq("bs_col", 32'(ccol1), 32'h1);
        read_cell(0, 0);
        check_eq("bs_cell0", 32'(chr1), 32'h41);
        read_cell(0, 1);
        check_eq("bs_cell1", 32'(chr1), 32'h20);
        send(8'h08);
        send(8'h08);
        check_eq("bs_floor", 32'(ccol1), 32'h0);
        scan_all();

        // 17 printables then three LFs: bottom-row scroll versus wrap to top
        send(8'h0C);
        settle();
        for (int i = 0; i < 17; i++) send(8'h41 + 8'(i));
        send(8'h0A);
        send(8'h0A);
        cnt0 = 0;
        cnt1 = 0;
        send(8'h0A);
        for (int i = 0; i < 3 * COLS; i++) begin
            if (!busy0 && !busy1) break;
            if (busy0) cnt0++;
            if (busy1) cnt1++;
            tick(1'b0, 8'h00);
        end
        check_eq("rowclr_cycles_wrap", 32'(cnt0), 32'(COLS));
        check_eq("rowclr_cycles_scroll", 32'(cnt1), 32'(COLS));
        check_eq("wrap_cursor_row", 32'(crow0), 32'h0);
        check_eq("scroll_cursor_row", 32'(crow1), 32'h3);
        read_cell(0, 0);
        check_eq("scroll_row0", 32'(chr1), 32'h51);
        check_eq("wrap_row0", 32'(chr0), 32'h20);
        read_cell(1, 0);
        check_eq("wrap_row1", 32'(chr0), 32'h51);
        scan_all();

        // Three strobes during a row clear: first held, two dropped
        send(8'h0C);
        settle();
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
        send(8'h0A);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) send(8'h58 + 8'(i));
            else tick(1'b0, 8'h00);
            if (drop0) cnt0++;
            if (drop1) cnt1++;
        end
        check_eq("drops_wrap", 32'(cnt0), 32'h2);
        check_eq("drops_scroll", 32'(cnt1), 32'h2);
        scan_all();

        // Form feed mid-text, then reset during the resulting full clear
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        send(8'h0C);
        for (int i = 0; i < 7; i++) tick(1'b0, 8'h00);
        rst = 1'b1;
        tick(1'b0, 8'h00);
        rst = 1'b0;
        scan_all();

        // Randomized byte streams with periodic full-screen comparison
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 150; i++) begin
                pick = $urandom_range(0, 99);
                if (pick < 70) b = 8'($urandom_range(32, 126));
                else if (pick < 78) b = 8'h0A;
                else if (pick < 84) b = 8'h0D;
                else if (pick < 92) b = 8'h08;
                else if (pick < 94) b = 8'h0C;
                else b = 8'($urandom_range(0, 255));
                tick(1'($urandom_range(0, 1)), b);
            end
            scan_all();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
